// File: rtl/pinball_pkg.sv
// Shared types and constants for the pinball collision logic.
package pinball_pkg;

  typedef enum logic [1:0] {
    ARMED,
    FIRED,
    COOLDOWN
  } hit_state_t;

  localparam int unsigned DEFAULT_COOLDOWN_FRAMES = 4;

endpackage

// File: rtl/frame_hit_latch.sv
// One collision channel: fires at most once per frame, then optionally stays
// suppressed for COOLDOWN_FRAMES further frames before re-arming.
module frame_hit_latch
  import pinball_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES
) (
  input  logic clk,
  input  logic resetN,
  input  logic start_of_frame,
  input  logic pause,
  input  logic overlap,
  output logic fire
);

  localparam int unsigned CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  hit_state_t      state, state_next;
  logic [CD_W-1:0] cd_cnt, cd_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= ARMED;
      cd_cnt <= '0;
    end else begin
      state  <= state_next;
      cd_cnt <= cd_next;
    end
  end

  // Pause freezes everything, including startOfFrame bookkeeping.
  always_comb begin
    state_next = state;
    cd_next    = cd_cnt;
    if (!pause) begin
      case (state)
        ARMED: begin
          if (fire) begin
            state_next = FIRED;
            cd_next    = CD_LOAD;
          end
        end
        FIRED: begin
          if (start_of_frame) state_next = (cd_cnt != '0) ? COOLDOWN : ARMED;
        end
        COOLDOWN: begin
          if (start_of_frame) begin
            cd_next = (cd_cnt != '0) ? cd_cnt - 1'b1 : '0;
            if (cd_cnt <= CD_W'(1)) state_next = ARMED;
          end
        end
        default: state_next = ARMED;
      endcase
    end
  end

  // Zero-latency output so the event lines up with the smiley's same-pixel edge code.
  always_comb begin
    fire = resetN & (state == ARMED) & overlap & ~pause & ~start_of_frame;
  end

endmodule

// File: rtl/smiley_collision_detector.sv
// Detects smiley/border and smiley/flipper pixel overlap and emits one event
// per type per frame, plus a saturating flipper-hit count.
module smiley_collision_detector
  import pinball_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               draw_smiley,
  input  logic               draw_borders,
  input  logic               draw_flipper,
  input  logic               pause,
  output logic               collisionSmileyBorders,
  output logic               collisionSmileyFlipper,
  output logic [COUNT_W-1:0] hitCount
);

  logic ov_b;
  logic ov_f;

  assign ov_b = draw_smiley & draw_borders;
  assign ov_f = draw_smiley & draw_flipper;

  frame_hit_latch #(
    .COOLDOWN_FRAMES(0)
  ) u_border (
    .clk           (clk),
    .resetN        (resetN),
    .start_of_frame(startOfFrame),
    .pause         (pause),
    .overlap       (ov_b),
    .fire          (collisionSmileyBorders)
  );

  frame_hit_latch #(
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_flipper (
    .clk           (clk),
    .resetN        (resetN),
    .start_of_frame(startOfFrame),
    .pause         (pause),
    .overlap       (ov_f),
    .fire          (collisionSmileyFlipper)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitCount <= '0;
    end else if (collisionSmileyFlipper && (hitCount != '1)) begin
      hitCount <= hitCount + 1'b1;
    end
  end

endmodule
